ctl_missile_en_pool: RTL and testbench
======================================

// Module: ctl_missile_en_pool
// PURPOSE
//  Multi-slot enemy missile controller. Manages N_MISSILES independent downward-flying
//  missiles for one enemy, with a shared speed prescaler, a fire cooldown and per-slot hit cancel.
//  Sits between the enemy position/fire logic and the missile draw stage, which consumes the
//  flat position/on vectors.
// PARAMETERS
//  N_MISSILES  4      number of missile slots (1..8)
//  SPEED_DIV   90000  pclk cycles per movement tick (>=2)
//  STEP        1      pixels added to y per tick (1..15)
//  Y_MAX       768    y at/after which a missile retires; Y_MAX+STEP <= 4095
//  COOLDOWN    0      ticks after an accepted fire during which fire is ignored (0 = none)
// PORTS
//  pclk         in   1              pixel clock
//  rst          in   1              reset, synchronous, active-high
//  xpos_in      in   12             enemy missile launch x
//  ypos_in      in   12             enemy missile launch y
//  fire         in   1              fire request, level; sampled every cycle
//  enemy_alive  in   1              fire is accepted only when 1
//  hit          in   N_MISSILES     per-slot cancel (collision), one-cycle pulse
//  xpos_out     out  12*N_MISSILES  slot i x at [12*i+11:12*i]
//  ypos_out     out  12*N_MISSILES  slot i y at [12*i+11:12*i]
//  on_out       out  N_MISSILES     slot i flying/visible
//  fire_ack     out  1              1-cycle pulse: fire accepted into a slot
//  fire_drop    out  1              1-cycle pulse: fire && enemy_alive && cooldown==0, but no slot free
// BEHAVIOUR
//  - All outputs registered. Reset: xpos_out=0, ypos_out=0, on_out=0, fire_ack=0, fire_drop=0,
//    prescaler=0, cooldown=0, all slots IDLE. rst mid-flight kills all missiles on the next edge.
//  - Per slot FSM: IDLE -> FLY on allocation; FLY -> IDLE on hit[i] or retire. No other states.
//  - Allocation: when fire && enemy_alive && cooldown==0, the lowest-index slot whose registered
//    state is IDLE is chosen. At the next edge: x <- xpos_in, y <- ypos_in, on=1, fire_ack=1.
//    Latency fire -> on_out = 1 cycle. At most one allocation per cycle.
//  - No free slot: fire_drop=1 for one cycle, nothing else changes. A fire held high allocates
//    again on a later cycle once cooldown allows.
//  - Prescaler: free-running 0..SPEED_DIV-1; tick = (count == SPEED_DIV-1), then wraps to 0.
//    It is not reset by fire.
//  - On tick, every FLY slot not hit this cycle: y <- y+STEP (12-bit, no wrap by constraint).
//    If y+STEP >= Y_MAX, the slot retires at that edge: on=0, state IDLE, y holds y+STEP.
//  - A slot allocated this cycle does not move on this cycle's tick.
//  - hit[i] on a FLY slot: on=0, IDLE at the next edge. It takes priority over the tick.
//    hit on an IDLE slot is ignored.
//  - A slot freed by hit or retire becomes allocatable on the following cycle, not the same one.
//  - IDLE slots hold their last x/y with on=0.
//  - Cooldown: on accept, cooldown <- COOLDOWN. It decrements by 1 per tick down to 0.
//    Fire is ignored silently (no ack/drop) while cooldown != 0.
//  - enemy_alive=0 blocks new fires only. Missiles in flight continue.
// TESTING  (N_MISSILES=2, SPEED_DIV=4, STEP=2, Y_MAX=20, COOLDOWN=0 unless noted)
//  1 fire=1 one cycle, x=100, y=10, alive=1 -> next cycle on_out=01, x0=100, y0=10, fire_ack pulse;
//    y0 steps 12,14,16,18 every 4 cycles; at y0+2>=20, on_out[0]=0, y0=20.
//  2 fire held 3 cycles -> slots 0 and 1 fill on consecutive cycles; third cycle -> fire_drop=1,
//    on_out=11.
//  3 both slots flying, hit=01 coincident with tick -> slot0 off, y0 not incremented; slot1 moves;
//    fire next cycle reuses slot0.
//  4 COOLDOWN=2: fire held continuously -> accepts spaced by 2 ticks (8 cycles), no drop/ack
//    pulses between.
//  5 alive=0 with fire=1 -> no ack, no drop, on_out unchanged; in-flight slot keeps moving.
//  6 rst asserted while on_out=11 -> next cycle all outputs 0; fire two cycles later allocates slot0.

Source files
------------

// File: rtl/ctl_missile_en_pool.sv
// ctl_missile_en_pool
//   Multi-slot enemy missile controller. Up to N_MISSILES missiles fly downward
//   independently. They share a speed prescaler and a fire cooldown, and each
//   slot can be cancelled by its own hit pulse. The position and on vectors are
//   flat so the missile draw stage can consume them directly.
//
// Ports
//   pclk         in   pixel clock
//   rst          in   synchronous, active-high reset; clears every slot and all outputs
//   xpos_in      in   [11:0] launch x for the next accepted missile
//   ypos_in      in   [11:0] launch y for the next accepted missile
//   fire         in   level fire request, sampled every cycle
//   enemy_alive  in   fire is accepted only while this is high
//   hit          in   [N_MISSILES-1:0] per-slot cancel pulse
//   xpos_out     out  [12*N_MISSILES-1:0] slot i x at [12*i+11:12*i]
//   ypos_out     out  [12*N_MISSILES-1:0] slot i y at [12*i+11:12*i]
//   on_out       out  [N_MISSILES-1:0] slot i is flying
//   fire_ack     out  one-cycle pulse: a fire was placed into a slot
//   fire_drop    out  one-cycle pulse: a fire was eligible but every slot was busy
module ctl_missile_en_pool #(
    parameter int N_MISSILES = 4,
    parameter int SPEED_DIV  = 90000,
    parameter int STEP       = 1,
    parameter int Y_MAX      = 768,
    parameter int COOLDOWN   = 0
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic [11:0]               xpos_in,
    input  logic [11:0]               ypos_in,
    input  logic                      fire,
    input  logic                      enemy_alive,
    input  logic [N_MISSILES-1:0]     hit,
    output logic [12*N_MISSILES-1:0]  xpos_out,
    output logic [12*N_MISSILES-1:0]  ypos_out,
    output logic [N_MISSILES-1:0]     on_out,
    output logic                      fire_ack,
    output logic                      fire_drop
);

    localparam int PS_W  = (SPEED_DIV > 2) ? $clog2(SPEED_DIV) : 1;
    localparam int CD_W  = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam int IDX_W = (N_MISSILES > 1) ? $clog2(N_MISSILES) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FLY  = 1'b1
    } slot_state_t;

    slot_state_t       r_state     [N_MISSILES];
    slot_state_t       w_state_nxt [N_MISSILES];
    logic [11:0]       r_x         [N_MISSILES];
    logic [11:0]       r_y         [N_MISSILES];
    logic [11:0]       w_x_nxt     [N_MISSILES];
    logic [11:0]       w_y_nxt     [N_MISSILES];
    logic [11:0]       w_y_step    [N_MISSILES];

    logic [PS_W-1:0]   r_presc;
    logic              w_tick;
    logic [CD_W-1:0]   r_cd;
    logic [CD_W-1:0]   w_cd_nxt;
    logic              r_ack;
    logic              r_drop;
    logic              w_ack_nxt;
    logic              w_drop_nxt;
    logic              w_fire_ok;
    logic              w_found;
    logic [IDX_W-1:0]  w_idx;

    assign w_tick    = (r_presc == PS_W'(SPEED_DIV - 1));
    assign w_fire_ok = fire && enemy_alive && (r_cd == '0);

    // Free-running movement prescaler; fire never restarts it.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    // Lowest-index free slot, judged on registered state only, so a slot
    // released this cycle cannot be re-used until the following cycle.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = N_MISSILES - 1; i >= 0; i--) begin
            if (r_state[i] == S_IDLE) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(i);
            end
        end
    end

    // Next-state / next-output logic for all slots.
    always_comb begin
        w_ack_nxt  = 1'b0;
        w_drop_nxt = 1'b0;
        w_cd_nxt   = r_cd;
        for (int i = 0; i < N_MISSILES; i++) begin
            w_state_nxt[i] = r_state[i];
            w_x_nxt[i]     = r_x[i];
            w_y_nxt[i]     = r_y[i];
            w_y_step[i]    = r_y[i] + 12'(STEP);
        end

        // Hit outranks the tick: a cancelled missile does not advance.
        for (int i = 0; i < N_MISSILES; i++) begin
            if (r_state[i] == S_FLY) begin
                if (hit[i]) begin
                    w_state_nxt[i] = S_IDLE;
                end else if (w_tick) begin
                    w_y_nxt[i] = w_y_step[i];
                    if ({1'b0, w_y_step[i]} >= 13'(Y_MAX)) begin
                        w_state_nxt[i] = S_IDLE;
                    end
                end
            end
        end

        // The chosen slot is IDLE, so the movement loop above never touched it.
        if (w_fire_ok) begin
            if (w_found) begin
                w_state_nxt[w_idx] = S_FLY;
                w_x_nxt[w_idx]     = xpos_in;
                w_y_nxt[w_idx]     = ypos_in;
                w_ack_nxt          = 1'b1;
            end else begin
                w_drop_nxt = 1'b1;
            end
        end

        if (w_fire_ok && w_found) begin
            w_cd_nxt = CD_W'(COOLDOWN);
        end else if (w_tick && (r_cd != '0)) begin
            w_cd_nxt = r_cd - CD_W'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < N_MISSILES; i++) begin
                r_state[i] <= S_IDLE;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
            end
            r_cd   <= '0;
            r_ack  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            for (int i = 0; i < N_MISSILES; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_x[i]     <= w_x_nxt[i];
                r_y[i]     <= w_y_nxt[i];
            end
            r_cd   <= w_cd_nxt;
            r_ack  <= w_ack_nxt;
            r_drop <= w_drop_nxt;
        end
    end

    for (genvar g = 0; g < N_MISSILES; g++) begin : g_out
        assign xpos_out[12*g +: 12] = r_x[g];
        assign ypos_out[12*g +: 12] = r_y[g];
        assign on_out[g]            = (r_state[g] == S_FLY);
    end

    assign fire_ack  = r_ack;
    assign fire_drop = r_drop;

endmodule

// File: tb/tb_ctl_missile_en_pool.sv
// Bench for ctl_missile_en_pool: two instances (no cooldown and COOLDOWN=2)
// share one stimulus stream; a reference model predicts each cycle's outputs
// into per-instance queues that a separate monitor drains and compares.
module tb_ctl_missile_en_pool;

    localparam int N    = 2;
    localparam int DIV  = 4;
    localparam int STP  = 2;
    localparam int YMAX = 20;

    logic             pclk = 1'b0;
    logic             rst  = 1'b1;
    logic [11:0]      xin  = '0;
    logic [11:0]      yin  = '0;
    logic             fire = 1'b0;
    logic             alive = 1'b0;
    logic [N-1:0]     hit  = '0;

    logic [12*N-1:0]  xo0, yo0, xo1, yo1;
    logic [N-1:0]     on0, on1;
    logic             ack0, drop0, ack1, drop1;

    always #5 pclk = ~pclk;

    ctl_missile_en_pool #(
        .N_MISSILES(N), .SPEED_DIV(DIV), .STEP(STP), .Y_MAX(YMAX), .COOLDOWN(0)
    ) u_dut0 (
        .pclk(pclk), .rst(rst), .xpos_in(xin), .ypos_in(yin), .fire(fire),
        .enemy_alive(alive), .hit(hit), .xpos_out(xo0), .ypos_out(yo0),
        .on_out(on0), .fire_ack(ack0), .fire_drop(drop0)
    );

    ctl_missile_en_pool #(
        .N_MISSILES(N), .SPEED_DIV(DIV), .STEP(STP), .Y_MAX(YMAX), .COOLDOWN(2)
    ) u_dut1 (
        .pclk(pclk), .rst(rst), .xpos_in(xin), .ypos_in(yin), .fire(fire),
        .enemy_alive(alive), .hit(hit), .xpos_out(xo1), .ypos_out(yo1),
        .on_out(on1), .fire_ack(ack1), .fire_drop(drop1)
    );

    typedef struct {
        logic [N-1:0]    on;
        logic [12*N-1:0] x;
        logic [12*N-1:0] y;
        logic            ack;
        logic            drop;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state, one row per instance.
    bit m_fly [2][N];
    int m_x   [2][N];
    int m_y   [2][N];
    int m_ps  [2];
    int m_cd  [2];

    int n_chk  = 0;
    int n_pass = 0;
    bit done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock edge of the pool, written as plain rules over the slot list.
    task automatic model_step(input int k, input int cool, output exp_t e);
        bit tick;
        int free_slot;
        bit accepted;
        e.ack  = 1'b0;
        e.drop = 1'b0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_fly[k][i] = 1'b0;
                m_x[k][i]   = 0;
                m_y[k][i]   = 0;
            end
            m_ps[k] = 0;
            m_cd[k] = 0;
        end else begin
            tick      = (m_ps[k] == DIV - 1);
            accepted  = 1'b0;
            free_slot = -1;
            for (int i = N - 1; i >= 0; i--)
                if (!m_fly[k][i]) free_slot = i;
            for (int i = 0; i < N; i++) begin
                if (m_fly[k][i]) begin
                    if (hit[i]) m_fly[k][i] = 1'b0;
                    else if (tick) begin
                        m_y[k][i] = m_y[k][i] + STP;
                        if (m_y[k][i] >= YMAX) m_fly[k][i] = 1'b0;
                    end
                end
            end
            if (fire && alive && m_cd[k] == 0) begin
                if (free_slot >= 0) begin
                    m_fly[k][free_slot] = 1'b1;
                    m_x[k][free_slot]   = int'(xin);
                    m_y[k][free_slot]   = int'(yin);
                    e.ack    = 1'b1;
                    accepted = 1'b1;
                end else begin
                    e.drop = 1'b1;
                end
            end
            if (accepted) m_cd[k] = cool;
            else if (tick && m_cd[k] > 0) m_cd[k] = m_cd[k] - 1;
            m_ps[k] = tick ? 0 : m_ps[k] + 1;
        end
        for (int i = 0; i < N; i++) begin
            e.on[i]         = m_fly[k][i];
            e.x[12*i +: 12] = m_x[k][i][11:0];
            e.y[12*i +: 12] = m_y[k][i][11:0];
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue the prediction.
    task automatic cyc(input logic f, input logic a, input logic [N-1:0] h,
                       input logic [11:0] x, input logic [11:0] y, input logic r);
        exp_t e0, e1;
        @(negedge pclk);
        fire  = f;
        alive = a;
        hit   = h;
        xin   = x;
        yin   = y;
        rst   = r;
        model_step(0, 0, e0);
        model_step(1, 2, e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    // Monitor: outputs settle after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge pclk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("on0",   32'(on0),   32'(e.on));
                check("x0",    32'(xo0),   32'(e.x));
                check("y0",    32'(yo0),   32'(e.y));
                check("ack0",  32'(ack0),  32'(e.ack));
                check("drop0", 32'(drop0), 32'(e.drop));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("on1",   32'(on1),   32'(e.on));
                check("x1",    32'(xo1),   32'(e.x));
                check("y1",    32'(yo1),   32'(e.y));
                check("ack1",  32'(ack1),  32'(e.ack));
                check("drop1", 32'(drop1), 32'(e.drop));
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 12'd0, 12'd0, 1'b1);
        // Single shot flying to retirement.
        cyc(1'b1, 1'b1, '0, 12'd100, 12'd10, 1'b0);
        for (int i = 0; i < 22; i++) cyc(1'b0, 1'b1, '0, 12'd0, 12'd0, 1'b0);
        // Held fire fills both slots then drops.
        cyc(1'b1, 1'b1, '0, 12'd200, 12'd0, 1'b0);
        cyc(1'b1, 1'b1, '0, 12'd300, 12'd2, 1'b0);
        cyc(1'b1, 1'b1, '0, 12'd400, 12'd4, 1'b0);
        // Enemy dead: fire blocked, missiles keep moving.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, '0, 12'd500, 12'd6, 1'b0);
        // Cancel slot 0, then refill it.
        cyc(1'b0, 1'b1, 2'b01, 12'd0, 12'd0, 1'b0);
        cyc(1'b1, 1'b1, '0, 12'd600, 12'd1, 1'b0);
        cyc(1'b1, 1'b1, 2'b10, 12'd700, 12'd3, 1'b0);
        // Reset mid-flight, then fire two cycles later.
        cyc(1'b0, 1'b1, '0, 12'd0, 12'd0, 1'b1);
        cyc(1'b0, 1'b1, '0, 12'd0, 12'd0, 1'b0);
        cyc(1'b1, 1'b1, '0, 12'd800, 12'd5, 1'b0);
        // Continuous fire, exercises cooldown spacing.
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, '0, 12'(i), 12'd8, 1'b0);
        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 8),
                {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)},
                12'($urandom_range(0, 4095)), 12'($urandom_range(0, 22)),
                ($urandom_range(0, 199) == 0));
        end
        cyc(1'b0, 1'b0, '0, 12'd0, 12'd0, 1'b0);
        repeat (3) @(posedge pclk);
        #2;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d/%0d predictions left unchecked", q0.size(), q1.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        done = 1'b1;
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
            $fatal(1);
        end
    end

endmodule
